// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller.
// Holds the opcode/funct constants of the supported instruction subset,
// the encodings of every mux/ALU select driven by the controller, the FSM
// state enum and the one-hot instruction-class struct produced by decode.
package mips_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    // Immediate extender
    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_HIGH = 2'b10;

    // ALU operation
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;

    // Next-PC source
    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_J    = 2'b10;

    // Register-file write data source
    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_DM    = 2'b01;
    localparam logic [1:0] WD_PC4   = 2'b10;

    // Register-file destination
    localparam logic [1:0] A3_RD    = 2'b00;
    localparam logic [1:0] A3_RT    = 2'b01;
    localparam logic [1:0] A3_RA    = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DCD    = 3'd1,
        S_EXE    = 3'd2,
        S_MEM_RD = 3'd3,
        S_MEM_WR = 3'd4,
        S_WB_ALU = 3'd5,
        S_WB_MEM = 3'd6
    } state_t;

    // One-hot instruction class; all-zero means unsupported
    typedef struct packed {
        logic addu;
        logic subu;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
    } instr_cls_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder for the multi-cycle controller.
// Ports:
//   i_op      in   6  opcode from IR
//   i_funct   in   6  function code from IR
//   o_cls     out  9  one-hot instruction class (instr_cls_t)
//   o_illegal out  1  op/funct combination not in the supported subset
module mc_decode
    import mips_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [5:0]  i_funct,
    output instr_cls_t  o_cls,
    output logic        o_illegal
);

    always_comb begin
        o_cls = '0;
        case (i_op)
            OP_RTYPE: begin
                o_cls.addu = (i_funct == FN_ADDU);
                o_cls.subu = (i_funct == FN_SUBU);
            end
            OP_ORI:  o_cls.ori = 1'b1;
            OP_LUI:  o_cls.lui = 1'b1;
            OP_LW:   o_cls.lw  = 1'b1;
            OP_SW:   o_cls.sw  = 1'b1;
            OP_BEQ:  o_cls.beq = 1'b1;
            OP_J:    o_cls.j   = 1'b1;
            OP_JAL:  o_cls.jal = 1'b1;
            default: ;
        endcase
    end

    // Anything that matched no class, including R-type with unknown funct
    assign o_illegal = (o_cls == '0);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle sequencer for the MIPS datapath. Walks each instruction through
// FETCH / DCD / EXE / MEM / WB and drives the datapath write enables and
// mux/ALU selects per phase; counts retired instructions.
// Ports:
//   clk       in   1      clock, rising edge
//   rst       in   1      asynchronous active-low reset
//   op        in   6      instr[31:26] from IR
//   funct     in   6      instr[5:0] from IR
//   zero      in   1      ALU zero flag (used in EXE for beq)
//   dm_rdy    in   1      data memory done handshake
//   PCWr/IRWr/RFWr/DMWr/DMRd  out  1  write enables / read request
//   EXTOp/ALUOp/NPCOp/WDSel/A3Sel  out 2  select fields
//   BSel      out  1      ALU B source
//   illegal   out  1      pulse in DCD for unsupported op/funct
//   instr_cnt out  CNT_W  retired instruction count (wraps)
module mc_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter bit DM_WAIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             dm_rdy,
    output logic             PCWr,
    output logic             IRWr,
    output logic             RFWr,
    output logic             DMWr,
    output logic             DMRd,
    output logic [1:0]       EXTOp,
    output logic [1:0]       ALUOp,
    output logic [1:0]       NPCOp,
    output logic             BSel,
    output logic [1:0]       WDSel,
    output logic [1:0]       A3Sel,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    instr_cls_t       w_cls;
    logic             w_illegal;
    logic             w_dm_go;
    logic             w_retire;
    logic [1:0]       w_alu_op;
    logic [1:0]       w_ext_op;
    logic             w_bsel;

    mc_decode u_decode (
        .i_op      (op),
        .i_funct   (funct),
        .o_cls     (w_cls),
        .o_illegal (w_illegal)
    );

    // With DM_WAIT=0 the memory is assumed to finish in a single cycle
    assign w_dm_go = dm_rdy | ~DM_WAIT;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_FETCH;
        else      r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = S_DCD;
            S_DCD: begin
                if (w_illegal || w_cls.j || w_cls.jal) w_next = S_FETCH;
                else                                   w_next = S_EXE;
            end
            S_EXE: begin
                if (w_cls.lw)       w_next = S_MEM_RD;
                else if (w_cls.sw)  w_next = S_MEM_WR;
                else if (w_cls.beq) w_next = S_FETCH;
                else                w_next = S_WB_ALU;
            end
            S_MEM_RD: if (w_dm_go) w_next = S_WB_MEM;
            S_MEM_WR: if (w_dm_go) w_next = S_FETCH;
            S_WB_ALU: w_next = S_FETCH;
            S_WB_MEM: w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    // An instruction retires whenever control returns to FETCH, except when
    // DCD rejected it as illegal.
    assign w_retire = (r_state != S_FETCH) && (w_next == S_FETCH) &&
                      !((r_state == S_DCD) && w_illegal);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          r_cnt <= '0;
        else if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
    end

    assign instr_cnt = r_cnt;

    // Execute-phase selects per class. IR is only rewritten in FETCH, so these
    // stay stable from EXE through MEM and WB, keeping the ALU result / memory
    // address steady while the memory handshake is pending.
    always_comb begin
        w_alu_op = ALU_ADD;
        w_ext_op = EXT_ZERO;
        w_bsel   = 1'b0;
        if (w_cls.subu || w_cls.beq) w_alu_op = ALU_SUB;
        if (w_cls.ori) begin
            w_alu_op = ALU_OR;
            w_bsel   = 1'b1;
        end
        if (w_cls.lui) begin
            w_ext_op = EXT_HIGH;
            w_bsel   = 1'b1;
        end
        if (w_cls.lw || w_cls.sw) begin
            w_ext_op = EXT_SIGN;
            w_bsel   = 1'b1;
        end
    end

    // Output logic. Everything is forced low while rst is asserted so that no
    // write can complete once reset arrives mid-instruction.
    always_comb begin
        PCWr    = 1'b0;
        IRWr    = 1'b0;
        RFWr    = 1'b0;
        DMWr    = 1'b0;
        DMRd    = 1'b0;
        EXTOp   = EXT_ZERO;
        ALUOp   = ALU_ADD;
        NPCOp   = NPC_PC4;
        BSel    = 1'b0;
        WDSel   = WD_ALU;
        A3Sel   = A3_RD;
        illegal = 1'b0;
        if (rst) begin
            case (r_state)
                S_FETCH: begin
                    IRWr  = 1'b1;
                    PCWr  = 1'b1;
                    NPCOp = NPC_PC4;
                end
                S_DCD: begin
                    if (w_illegal) begin
                        illegal = 1'b1;
                    end else if (w_cls.j || w_cls.jal) begin
                        PCWr  = 1'b1;
                        NPCOp = NPC_J;
                        if (w_cls.jal) begin
                            RFWr  = 1'b1;
                            A3Sel = A3_RA;
                            WDSel = WD_PC4;
                        end
                    end
                end
                S_EXE: begin
                    ALUOp = w_alu_op;
                    EXTOp = w_ext_op;
                    BSel  = w_bsel;
                    if (w_cls.beq) begin
                        // Branch decision is Mealy on the live zero flag
                        PCWr  = zero;
                        NPCOp = NPC_BR;
                    end
                end
                S_MEM_RD: begin
                    ALUOp = w_alu_op;
                    EXTOp = w_ext_op;
                    BSel  = w_bsel;
                    DMRd  = 1'b1;
                end
                S_MEM_WR: begin
                    ALUOp = w_alu_op;
                    EXTOp = w_ext_op;
                    BSel  = w_bsel;
                    DMWr  = 1'b1;
                end
                S_WB_ALU: begin
                    ALUOp = w_alu_op;
                    EXTOp = w_ext_op;
                    BSel  = w_bsel;
                    RFWr  = 1'b1;
                    WDSel = WD_ALU;
                    A3Sel = (w_cls.addu || w_cls.subu) ? A3_RD : A3_RT;
                end
                S_WB_MEM: begin
                    ALUOp = w_alu_op;
                    EXTOp = w_ext_op;
                    BSel  = w_bsel;
                    RFWr  = 1'b1;
                    WDSel = WD_DM;
                    A3Sel = A3_RT;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl (CNT_W=4, DM_WAIT=1). Each scenario pushes
// the per-cycle expected control vector onto a scoreboard queue, then drains
// it cycle by cycle against the DUT outputs.
module tb_mc_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       dm_rdy;
    logic       PCWr, IRWr, RFWr, DMWr, DMRd, BSel, illegal;
    logic [1:0] EXTOp, ALUOp, NPCOp, WDSel, A3Sel;
    logic [3:0] instr_cnt;

    mc_ctrl #(.CNT_W(4), .DM_WAIT(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .dm_rdy    (dm_rdy),
        .PCWr      (PCWr),
        .IRWr      (IRWr),
        .RFWr      (RFWr),
        .DMWr      (DMWr),
        .DMRd      (DMRd),
        .EXTOp     (EXTOp),
        .ALUOp     (ALUOp),
        .NPCOp     (NPCOp),
        .BSel      (BSel),
        .WDSel     (WDSel),
        .A3Sel     (A3Sel),
        .illegal   (illegal),
        .instr_cnt (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWr,IRWr,RFWr,DMWr,DMRd,EXTOp,ALUOp,NPCOp,BSel,WDSel,A3Sel,illegal}
    logic [16:0] act;
    assign act = {PCWr, IRWr, RFWr, DMWr, DMRd, EXTOp, ALUOp, NPCOp,
                  BSel, WDSel, A3Sel, illegal};

    typedef struct packed {
        logic        rdy;
        logic [16:0] v;
    } ent_t;

    ent_t       q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] exp_cnt  = 4'd0;

    function automatic logic [16:0] ov(
        input logic pc, input logic ir, input logic rf, input logic dmw,
        input logic dmr, input logic [1:0] ext, input logic [1:0] alu,
        input logic [1:0] npc, input logic b, input logic [1:0] wd,
        input logic [1:0] a3, input logic ill);
        return {pc, ir, rf, dmw, dmr, ext, alu, npc, b, wd, a3, ill};
    endfunction

    task automatic push(input logic rdy, input logic [16:0] v);
        ent_t e;
        e.rdy = rdy;
        e.v   = v;
        q.push_back(e);
    endtask

    // Expected per-cycle vectors, written from the instruction-phase table.
    // nwait = number of MEM cycles with dm_rdy low before it rises.
    // noise = dm_rdy level driven during non-MEM cycles (must be ignored).
    task automatic load_instr(input logic [5:0] op_i, input logic [5:0] fn_i,
                              input logic z, input int nwait, input logic noise);
        logic [16:0] none;
        logic [16:0] mem;
        none = '0;
        push(noise, ov(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0));
        if (op_i == 6'h00 && fn_i == 6'h21) begin
            push(noise, none);
            push(noise, none);
            push(noise, ov(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0));
        end else if (op_i == 6'h00 && fn_i == 6'h23) begin
            push(noise, none);
            push(noise, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0));
            push(noise, ov(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0));
        end else if (op_i == 6'h0D) begin
            push(noise, none);
            push(noise, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0));
            push(noise, ov(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 1'b1, 2'd0, 2'd1, 1'b0));
        end else if (op_i == 6'h0F) begin
            push(noise, none);
            push(noise, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0));
            push(noise, ov(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 1'b1, 2'd0, 2'd1, 1'b0));
        end else if (op_i == 6'h23) begin
            push(noise, none);
            push(noise, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0));
            mem = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0);
            for (int i = 0; i < nwait; i++) push(1'b0, mem);
            push(1'b1, mem);
            push(noise, ov(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b1, 2'd1, 2'd1, 1'b0));
        end else if (op_i == 6'h2B) begin
            push(noise, none);
            push(noise, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0));
            mem = ov(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0);
            for (int i = 0; i < nwait; i++) push(1'b0, mem);
            push(1'b1, mem);
        end else if (op_i == 6'h04) begin
            push(noise, none);
            push(noise, ov(z, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0));
        end else if (op_i == 6'h02) begin
            push(noise, ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b0, 2'd0, 2'd0, 1'b0));
        end else if (op_i == 6'h03) begin
            push(noise, ov(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b0, 2'd2, 2'd2, 1'b0));
        end else begin
            push(noise, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1));
        end
    endtask

    // Entered just after a rising edge; one comparison per queued cycle
    task automatic drain(input string name);
        ent_t e;
        int   cyc;
        cyc = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            dm_rdy = e.rdy;
            @(negedge clk);
            n_checks++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s cycle %0d: outputs got %05h expected %05h", name, cyc, act, e.v);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        dm_rdy = 1'b0;
    endtask

    task automatic run(input string name, input logic [5:0] op_i, input logic [5:0] fn_i,
                       input logic z, input int nwait, input logic noise, input bit retires);
        op    = op_i;
        funct = fn_i;
        zero  = z;
        load_instr(op_i, fn_i, z, nwait, noise);
        drain(name);
        if (retires) exp_cnt = exp_cnt + 4'd1;
        n_checks++;
        if (instr_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL %s instr_cnt: got %0d expected %0d", name, instr_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (act !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %05h expected 00000", act);
        end
        n_checks++;
        if (instr_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d expected 0", instr_cnt);
        end
        rst     = 1'b1;
        exp_cnt = 4'd0;
    endtask

    task automatic test_alu();
        run("addu", 6'h00, 6'h21, 1'b0, 0, 1'b1, 1'b1);
        run("subu", 6'h00, 6'h23, 1'b0, 0, 1'b0, 1'b1);
        run("ori",  6'h0D, 6'h00, 1'b0, 0, 1'b1, 1'b1);
        run("lui",  6'h0F, 6'h3F, 1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_beq();
        run("beq_taken",     6'h04, 6'h00, 1'b1, 0, 1'b0, 1'b1);
        run("beq_not_taken", 6'h04, 6'h00, 1'b0, 0, 1'b1, 1'b1);
    endtask

    task automatic test_mem();
        run("lw_wait3", 6'h23, 6'h00, 1'b0, 3, 1'b0, 1'b1);
        run("sw_wait2", 6'h2B, 6'h00, 1'b0, 2, 1'b1, 1'b1);
        run("lw_wait0", 6'h23, 6'h00, 1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_jump();
        run("j",   6'h02, 6'h00, 1'b0, 0, 1'b0, 1'b1);
        run("jal", 6'h03, 6'h00, 1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_illegal();
        run("illegal_op",    6'h3F, 6'h00, 1'b0, 0, 1'b0, 1'b0);
        run("illegal_funct", 6'h00, 6'h20, 1'b0, 0, 1'b1, 1'b0);
    endtask

    // 16 jumps in a row: counter passes 15 -> 0 on the way
    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) run("b2b_j", 6'h02, 6'h00, 1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_mem();
        op    = 6'h23;
        funct = 6'h00;
        push(1'b0, ov(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0));
        push(1'b0, '0);
        push(1'b0, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0));
        push(1'b0, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0));
        push(1'b0, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0));
        drain("lw_before_reset");
        // Still in MEM_RD; assert reset between edges and look before any edge
        dm_rdy = 1'b1;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (act !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_mid_mem_outputs: got %05h expected 00000", act);
        end
        n_checks++;
        if (instr_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid_mem_cnt: got %0d expected 0", instr_cnt);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (act !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_held_outputs: got %05h expected 00000", act);
        end
        dm_rdy  = 1'b0;
        rst     = 1'b1;
        exp_cnt = 4'd0;
        run("addu_after_reset", 6'h00, 6'h21, 1'b0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        rst    = 1'b1;
        op     = 6'h00;
        funct  = 6'h00;
        zero   = 1'b0;
        dm_rdy = 1'b0;
        test_reset();
        test_alu();
        test_beq();
        test_mem();
        test_jump();
        test_illegal();
        test_back_to_back();
        test_reset_mid_mem();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
